// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared widths and types for the MVM engine datapath
package mvm_pkg;
    localparam int DWIDTH_DEF = 32;
    localparam int CWIDTH_DEF = 8;

    typedef logic signed [DWIDTH_DEF-1:0] acc_t;
    typedef logic [CWIDTH_DEF-1:0]        chunk_cnt_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO with push/pop/full/empty/count
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    // A pop frees a slot on the same edge, so a full FIFO can still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/dot_accum.sv
// rtl/dot_accum.sv - sums consecutive 8-lane partial dot products into row results
module dot_accum
    import mvm_pkg::*;
#(
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int CWIDTH     = CWIDTH_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ivalid,
    input  logic [DWIDTH-1:0] idata,
    input  logic [CWIDTH-1:0] num_chunks,
    input  logic              clear,
    output logic              ovalid,
    output logic [DWIDTH-1:0] odata,
    input  logic              oready,
    output logic              busy,
    output logic              overflow
);
    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic [CWIDTH-1:0] n_lat_q, n_lat_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic              push;
    logic [DWIDTH-1:0] sum;
    logic [CWIDTH-1:0] len_eff;
    logic              fifo_full, fifo_empty, pop;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

    assign len_eff = (num_chunks == '0) ? CWIDTH'(1) : num_chunks;
    assign pop     = oready && !fifo_empty;

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        n_lat_d = n_lat_q;
        push    = 1'b0;
        sum     = acc_q + idata;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (ivalid) begin
            if (cnt_q == '0) begin
                n_lat_d = len_eff;
                if (len_eff == CWIDTH'(1)) begin
                    push  = 1'b1;
                    sum   = idata;
                    acc_d = '0;
                end else begin
                    acc_d = idata;
                    cnt_d = CWIDTH'(1);
                end
            end else if (cnt_q == n_lat_q - CWIDTH'(1)) begin
                push  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = acc_q + idata;
                cnt_d = cnt_q + CWIDTH'(1);
            end
        end
        busy_d     = (cnt_d != '0);
        overflow_d = overflow_q | (push && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            n_lat_q    <= CWIDTH'(1);
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            n_lat_q    <= n_lat_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (DWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (sum),
        .pop   (pop),
        .rdata (odata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    assign ovalid   = !fifo_empty;
    assign busy     = busy_q;
    assign overflow = overflow_q;
endmodule
